// File: rtl/sargantana_icache_itlb_resp.sv
// ITLB responder for the instruction cache: fully associative lookup with a
// page-table-walk refill path and registered translation responses.
module sargantana_icache_itlb_resp #(
    parameter int unsigned ITLB_ENTRIES  = 8,
    parameter int unsigned VPN_BITS_SIZE = 28,
    parameter int unsigned PPN_BIT_SIZE  = 20
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     treq_valid_i,
    input  logic [VPN_BITS_SIZE-1:0] treq_vpn_i,
    input  logic                     treq_kill_i,
    input  logic                     flush_i,
    output logic                     tresp_miss_o,
    output logic                     tresp_ptw_v_o,
    output logic [PPN_BIT_SIZE-1:0]  tresp_ppn_o,
    output logic                     tresp_xcpt_o,
    output logic                     ptw_req_valid_o,
    output logic [VPN_BITS_SIZE-1:0] ptw_req_vpn_o,
    input  logic                     ptw_req_ready_i,
    input  logic                     ptw_resp_valid_i,
    input  logic [PPN_BIT_SIZE-1:0]  ptw_resp_ppn_i,
    input  logic                     ptw_resp_xcpt_i,
    output logic                     busy_o
);

    localparam int unsigned IDX_W = (ITLB_ENTRIES > 1) ? $clog2(ITLB_ENTRIES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTW_REQ  = 2'd1,
        PTW_WAIT = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ITLB_ENTRIES-1:0]  valid_q;
    logic [VPN_BITS_SIZE-1:0] tag_q     [ITLB_ENTRIES];
    logic [PPN_BIT_SIZE-1:0]  pte_ppn_q [ITLB_ENTRIES];
    logic [IDX_W-1:0]         rr_q;
    logic                     flushed_q;

    logic                     hit;
    logic [IDX_W-1:0]         hit_idx;
    logic                     free_found;
    logic [IDX_W-1:0]         victim;
    logic                     fill;
    logic                     fill_en;

    logic                     miss_d;
    logic                     ptw_v_d;
    logic [PPN_BIT_SIZE-1:0]  ppn_d;
    logic                     xcpt_d;
    logic [VPN_BITS_SIZE-1:0] req_vpn_d;

    // Tag match and victim choice: lowest free slot, else round-robin pointer
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        victim     = rr_q;
        for (int unsigned i = 0; i < ITLB_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == treq_vpn_i) && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                victim     = IDX_W'(i);
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        miss_d    = tresp_miss_o;
        ptw_v_d   = 1'b0;
        ppn_d     = tresp_ppn_o;
        xcpt_d    = 1'b0;
        req_vpn_d = ptw_req_vpn_o;
        fill      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (treq_valid_i) begin
                    if (hit) begin
                        miss_d = 1'b0;
                        ppn_d  = pte_ppn_q[hit_idx];
                    end else begin
                        miss_d    = 1'b1;
                        req_vpn_d = treq_vpn_i;
                        state_d   = PTW_REQ;
                    end
                end
            end
            PTW_REQ: begin
                if (treq_kill_i) begin
                    miss_d  = 1'b0;
                    state_d = IDLE;
                end else if (ptw_req_ready_i) begin
                    state_d = PTW_WAIT;
                end
            end
            PTW_WAIT: begin
                if (ptw_resp_valid_i) begin
                    ptw_v_d = 1'b1;
                    miss_d  = 1'b0;
                    ppn_d   = ptw_resp_ppn_i;
                    xcpt_d  = ptw_resp_xcpt_i;
                    fill    = !ptw_resp_xcpt_i;
                    state_d = IDLE;
                end else if (treq_kill_i) begin
                    miss_d  = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ptw_resp_valid_i) begin
                    fill    = !ptw_resp_xcpt_i;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush anywhere during the walk makes the result stale
    assign fill_en = fill && !flushed_q && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q         <= IDLE;
            tresp_miss_o    <= 1'b0;
            tresp_ptw_v_o   <= 1'b0;
            tresp_ppn_o     <= '0;
            tresp_xcpt_o    <= 1'b0;
            ptw_req_valid_o <= 1'b0;
            ptw_req_vpn_o   <= '0;
            busy_o          <= 1'b0;
            flushed_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tresp_miss_o    <= miss_d;
            tresp_ptw_v_o   <= ptw_v_d;
            tresp_ppn_o     <= ppn_d;
            tresp_xcpt_o    <= xcpt_d;
            ptw_req_valid_o <= (state_d == PTW_REQ);
            ptw_req_vpn_o   <= req_vpn_d;
            busy_o          <= (state_d != IDLE);
            if ((state_q == IDLE) && (state_d != IDLE)) begin
                flushed_q <= 1'b0;
            end else if (flush_i) begin
                flushed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (fill_en) begin
            valid_q[victim] <= 1'b1;
            if (&valid_q) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[victim]     <= ptw_req_vpn_o;
            pte_ppn_q[victim] <= ptw_resp_ppn_i;
        end
    end

endmodule

// File: tb/tb_sargantana_icache_itlb_resp.sv
// Scoreboard bench for sargantana_icache_itlb_resp: directed scenarios plus
// randomized traffic against an array-based ITLB reference model.
module tb_sargantana_icache_itlb_resp;

    localparam int N   = 8;
    localparam int VPW = 28;
    localparam int PPW = 20;

    localparam logic [1:0] K_HIT  = 2'd0;
    localparam logic [1:0] K_MISS = 2'd1;
    localparam logic [1:0] K_REQ  = 2'd2;
    localparam logic [1:0] K_PTWV = 2'd3;

    typedef struct packed {
        logic [1:0]     kind;
        logic [VPW-1:0] vpn;
        logic [PPW-1:0] ppn;
        logic           xcpt;
    } exp_t;

    logic           clk;
    logic           rstn_i;
    logic           treq_valid_i;
    logic [VPW-1:0] treq_vpn_i;
    logic           treq_kill_i;
    logic           flush_i;
    logic           tresp_miss_o;
    logic           tresp_ptw_v_o;
    logic [PPW-1:0] tresp_ppn_o;
    logic           tresp_xcpt_o;
    logic           ptw_req_valid_o;
    logic [VPW-1:0] ptw_req_vpn_o;
    logic           ptw_req_ready_i;
    logic           ptw_resp_valid_i;
    logic [PPW-1:0] ptw_resp_ppn_i;
    logic           ptw_resp_xcpt_i;
    logic           busy_o;

    sargantana_icache_itlb_resp #(
        .ITLB_ENTRIES (N),
        .VPN_BITS_SIZE(VPW),
        .PPN_BIT_SIZE (PPW)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .treq_valid_i    (treq_valid_i),
        .treq_vpn_i      (treq_vpn_i),
        .treq_kill_i     (treq_kill_i),
        .flush_i         (flush_i),
        .tresp_miss_o    (tresp_miss_o),
        .tresp_ptw_v_o   (tresp_ptw_v_o),
        .tresp_ppn_o     (tresp_ppn_o),
        .tresp_xcpt_o    (tresp_xcpt_o),
        .ptw_req_valid_o (ptw_req_valid_o),
        .ptw_req_vpn_o   (ptw_req_vpn_o),
        .ptw_req_ready_i (ptw_req_ready_i),
        .ptw_resp_valid_i(ptw_resp_valid_i),
        .ptw_resp_ppn_i  (ptw_resp_ppn_i),
        .ptw_resp_xcpt_i (ptw_resp_xcpt_i),
        .busy_o          (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_pass  = 0;
    int   n_total = 0;
    int   miss_cnt;
    exp_t exp_q[$];

    // Reference ITLB: plain arrays, victim = first free slot else rotating pointer
    bit             m_valid [N];
    logic [VPW-1:0] m_vpn   [N];
    logic [PPW-1:0] m_ppn   [N];
    int             m_rr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [1:0] k, input logic [VPW-1:0] v,
                                input logic [PPW-1:0] p, input logic x);
        exp_t e;
        e.kind = k; e.vpn = v; e.ppn = p; e.xcpt = x;
        return e;
    endfunction

    function automatic int m_lookup(input logic [VPW-1:0] v);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == v) return i;
        return -1;
    endfunction

    task automatic m_flush();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_rr = 0;
    endtask

    task automatic m_fill(input logic [VPW-1:0] v, input logic [PPW-1:0] p);
        int slot = -1;
        for (int i = 0; i < N; i++) if (!m_valid[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot = m_rr;
            m_rr = (m_rr + 1) % N;
        end
        m_valid[slot] = 1;
        m_vpn[slot]   = v;
        m_ppn[slot]   = p;
    endtask

    // Monitor: pops one expected event per observed DUT event
    task automatic mon_event(input logic [1:0] k, input logic [VPW-1:0] v,
                             input logic [PPW-1:0] p, input logic x);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got kind %0d, expected no event", k);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (k == e.kind) begin
            case (k)
                K_HIT:   begin check("hit_ppn", 64'(p), 64'(e.ppn)); check("hit_xcpt", 64'(x), 64'(0)); end
                K_REQ:   check("ptw_req_vpn", 64'(v), 64'(e.vpn));
                K_PTWV:  begin check("ptwv_ppn", 64'(p), 64'(e.ppn)); check("ptwv_xcpt", 64'(x), 64'(e.xcpt)); end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic           prev_busy = 1'b0;
        logic           prev_rv   = 1'b0;
        logic [VPW-1:0] prev_vpn  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn_i) begin
                prev_busy = 1'b0;
                prev_rv   = 1'b0;
                prev_vpn  = '0;
            end else begin
                if (treq_valid_i && !prev_busy)
                    mon_event(tresp_miss_o ? K_MISS : K_HIT, treq_vpn_i, tresp_ppn_o, tresp_xcpt_o);
                if (prev_rv && ptw_req_ready_i && !treq_kill_i)
                    mon_event(K_REQ, prev_vpn, '0, 1'b0);
                if (tresp_ptw_v_o)
                    mon_event(K_PTWV, '0, tresp_ppn_o, tresp_xcpt_o);
                prev_busy = busy_o;
                prev_rv   = ptw_req_valid_o;
                prev_vpn  = ptw_req_vpn_o;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (tresp_miss_o) miss_cnt++;
    endtask

    // mode: 0 plain walk, 1 kill with same-cycle ready, 2 kill in wait, 3 flush in wait
    task automatic do_req(input logic [VPW-1:0] vpn, input logic [PPW-1:0] ppn, input logic xcpt,
                          input int rdly, input int gap, input int mode, output logic was_miss);
        int idx;
        treq_valid_i = 1'b1;
        treq_vpn_i   = vpn;
        idx = m_lookup(vpn);
        if (idx >= 0) exp_q.push_back(mk(K_HIT, vpn, m_ppn[idx], 1'b0));
        else          exp_q.push_back(mk(K_MISS, vpn, '0, 1'b0));
        miss_cnt = 0;
        step();
        treq_valid_i = 1'b0;
        was_miss = tresp_miss_o;
        if (idx >= 0) return;
        repeat (rdly) step();
        if (mode == 1) begin
            treq_kill_i = 1'b1; ptw_req_ready_i = 1'b1;
            step();
            treq_kill_i = 1'b0; ptw_req_ready_i = 1'b0;
            check("kill_req_busy", 64'(busy_o), 64'(0));
            check("kill_req_miss", 64'(tresp_miss_o), 64'(0));
            return;
        end
        ptw_req_ready_i = 1'b1;
        exp_q.push_back(mk(K_REQ, vpn, '0, 1'b0));
        step();
        ptw_req_ready_i = 1'b0;
        if (mode == 2) begin
            treq_kill_i = 1'b1;
            step();
            treq_kill_i = 1'b0;
            check("kill_wait_miss", 64'(tresp_miss_o), 64'(0));
            check("kill_wait_busy", 64'(busy_o), 64'(1));
        end else if (mode == 3) begin
            flush_i = 1'b1;
            m_flush();
            step();
            flush_i = 1'b0;
        end
        repeat (gap) step();
        ptw_resp_valid_i = 1'b1; ptw_resp_ppn_i = ppn; ptw_resp_xcpt_i = xcpt;
        if (mode != 2) exp_q.push_back(mk(K_PTWV, '0, ppn, xcpt));
        if (!xcpt && mode != 3) m_fill(vpn, ppn);
        step();
        ptw_resp_valid_i = 1'b0; ptw_resp_xcpt_i = 1'b0;
        if (mode == 0) check("miss_cycles", 64'(miss_cnt), 64'(rdly + gap + 2));
        check("busy_after_walk", 64'(busy_o), 64'(0));
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        m_flush();
        step();
        flush_i = 1'b0;
    endtask

    initial begin
        logic wm;
        rstn_i = 1'b0; treq_valid_i = 1'b0; treq_vpn_i = '0; treq_kill_i = 1'b0;
        flush_i = 1'b0; ptw_req_ready_i = 1'b0; ptw_resp_valid_i = 1'b0;
        ptw_resp_ppn_i = '0; ptw_resp_xcpt_i = 1'b0;
        m_flush();
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({tresp_miss_o, tresp_ptw_v_o, tresp_ppn_o, tresp_xcpt_o,
                                    ptw_req_valid_o, ptw_req_vpn_o, busy_o}), 64'(0));
        rstn_i = 1'b1;
        step();

        // Cold miss then hit
        do_req(28'h0000123, 20'h0ABCD, 1'b0, 0, 1, 0, wm);
        check("cold_miss", 64'(wm), 64'(1));
        do_req(28'h0000123, 20'h0, 1'b0, 0, 0, 0, wm);
        check("rerequest_hit", 64'(wm), 64'(0));

        // Nine fills into eight entries: first one is evicted
        do_flush();
        for (int i = 0; i < 9; i++)
            do_req(28'h100 + 28'(i), 20'h200 + 20'(i), 1'b0, i % 3, i % 2, 0, wm);
        do_req(28'h100, 20'h2F0, 1'b0, 0, 0, 0, wm);
        check("evicted_first_miss", 64'(wm), 64'(1));
        do_req(28'h107, 20'h0, 1'b0, 0, 0, 0, wm);
        check("eighth_still_hit", 64'(wm), 64'(0));

        // Faulting walk is not cached
        do_req(28'h300, 20'h333, 1'b1, 1, 0, 0, wm);
        do_req(28'h300, 20'h334, 1'b0, 0, 0, 0, wm);
        check("xcpt_not_cached", 64'(wm), 64'(1));

        // Kill during wait still fills from the drained response
        do_req(28'h400, 20'h00055, 1'b0, 1, 2, 2, wm);
        do_req(28'h400, 20'h0, 1'b0, 0, 0, 0, wm);
        check("drain_fill_hit", 64'(wm), 64'(0));

        // Flush during wait: pulse but no fill, older entries gone
        do_req(28'h500, 20'h50A, 1'b0, 0, 0, 0, wm);
        do_req(28'h501, 20'h50B, 1'b0, 0, 1, 3, wm);
        do_req(28'h500, 20'h50C, 1'b0, 0, 0, 0, wm);
        check("flushed_old_miss", 64'(wm), 64'(1));
        do_req(28'h501, 20'h50D, 1'b0, 0, 0, 0, wm);
        check("flushed_walk_miss", 64'(wm), 64'(1));

        // Kill wins over same-cycle ready
        do_req(28'h600, 20'h0, 1'b0, 0, 0, 1, wm);
        do_req(28'h600, 20'h606, 1'b0, 0, 0, 0, wm);
        check("killed_req_miss", 64'(wm), 64'(1));

        // Reset in the middle of a walk; late response ignored
        do_req(28'h700, 20'h0, 1'b0, 0, 0, 1, wm);
        treq_valid_i = 1'b1; treq_vpn_i = 28'h701;
        exp_q.push_back(mk(K_MISS, 28'h701, '0, 1'b0));
        step();
        treq_valid_i = 1'b0; ptw_req_ready_i = 1'b1;
        exp_q.push_back(mk(K_REQ, 28'h701, '0, 1'b0));
        step();
        ptw_req_ready_i = 1'b0; rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        m_flush();
        check("midwalk_reset_busy", 64'(busy_o), 64'(0));
        check("midwalk_reset_miss", 64'(tresp_miss_o), 64'(0));
        ptw_resp_valid_i = 1'b1; ptw_resp_ppn_i = 20'h77777;
        step();
        ptw_resp_valid_i = 1'b0;
        check("late_resp_ignored", 64'({tresp_ptw_v_o, busy_o}), 64'(0));
        do_req(28'h701, 20'h701, 1'b0, 0, 0, 0, wm);
        check("after_reset_miss", 64'(wm), 64'(1));

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            int r = $urandom_range(0, 19);
            if (r == 0) begin
                do_flush();
            end else begin
                int mode = (r < 16) ? 0 : (r - 15);
                if (mode > 3) mode = 0;
                do_req(28'h4000 + 28'($urandom_range(0, 11)), 20'($urandom),
                       ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                       $urandom_range(0, 3), mode, wm);
            end
        end

        repeat (3) step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_itlb_resp.md
# sargantana_icache_itlb_resp

Instruction-side translation responder serving the instruction cache's MMU translation interface. It accepts a virtual page number per fetch request, looks it up in a small fully associative ITLB, and returns the miss, page-walk-valid, physical page number and exception fields that the cache registers in its pipeline. On a miss it issues a page-table-walk request, fills the ITLB from the walk result, and reports completion with a one-cycle page-walk-valid pulse.

## Interface
Parameters:
- ITLB_ENTRIES, 8, number of fully associative entries (power of two, ≥2)
- VPN_BITS_SIZE, 28, virtual page number width
- PPN_BIT_SIZE, 20, physical page number width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- treq_valid_i  in  1  translation request from the cache
- treq_vpn_i  in  VPN_BITS_SIZE  VPN to translate
- treq_kill_i  in  1  cache abandons the outstanding request
- flush_i  in  1  invalidate all ITLB entries (sfence.vma)
- tresp_miss_o  out  1  translation not yet available
- tresp_ptw_v_o  out  1  one-cycle pulse: walk finished, ppn/xcpt valid
- tresp_ppn_o  out  PPN_BIT_SIZE  translated PPN
- tresp_xcpt_o  out  1  walk fault; valid only with tresp_ptw_v_o
- ptw_req_valid_o  out  1  walk request
- ptw_req_vpn_o  out  VPN_BITS_SIZE  VPN to walk
- ptw_req_ready_i  in  1  walker accepts request
- ptw_resp_valid_i  in  1  walk result valid (one cycle)
- ptw_resp_ppn_i  in  PPN_BIT_SIZE  walked PPN
- ptw_resp_xcpt_i  in  1  walk fault
- busy_o  out  1  state ≠ IDLE

## Operation
- Entry: valid bit, VPN tag, PPN. Reset/flush: all valid = 0, round-robin pointer = 0.
- States: IDLE, PTW_REQ, PTW_WAIT, DRAIN.
- IDLE, treq_valid_i=1: compare treq_vpn_i against all valid tags. Hit → next cycle tresp_miss_o=0, tresp_ppn_o=entry PPN; stay IDLE (back-to-back requests accepted every cycle). Miss → latch VPN, next cycle tresp_miss_o=1, go PTW_REQ.
- treq_valid_i ignored outside IDLE.
- PTW_REQ: ptw_req_valid_o=1, ptw_req_vpn_o=latched VPN, held stable until ptw_req_ready_i; on handshake → PTW_WAIT. treq_kill_i → IDLE without handshake (kill wins over same-cycle ready).
- PTW_WAIT: on ptw_resp_valid_i → next cycle tresp_ptw_v_o=1, tresp_miss_o=0, tresp_ppn_o=ptw_resp_ppn_i, tresp_xcpt_o=ptw_resp_xcpt_i; → IDLE. treq_kill_i (without same-cycle resp) → DRAIN.
- DRAIN: wait ptw_resp_valid_i, no response pulse; → IDLE.
- Fill on walk result in PTW_WAIT or DRAIN only when ptw_resp_xcpt_i=0 and no flush occurred since the walk request was latched (sticky flag, cleared on leaving IDLE). Victim: lowest-index invalid entry; else round-robin pointer, which increments modulo ITLB_ENTRIES on every fill into a full ITLB (ITLB_ENTRIES-1 wraps to 0).
- Faulting translations are never stored; tresp_xcpt_o=0 on hits.
- flush_i: clears all valid bits at that edge; same-cycle fill is discarded (flush wins). Same-cycle IDLE lookup evaluates pre-flush contents. Flush does not change FSM state.

## Timing
- Reset values: tresp_miss_o=0, tresp_ptw_v_o=0, tresp_ppn_o=0, tresp_xcpt_o=0, ptw_req_valid_o=0, ptw_req_vpn_o=0, busy_o=0; state IDLE.
- All tresp_* outputs registered. Hit latency 1 cycle. Miss: tresp_miss_o=1 from request+1 through the cycle ptw_resp_valid_i is sampled; tresp_ptw_v_o pulses exactly one cycle after that.
- tresp_miss_o deasserts the cycle after a kill.
- tresp_ppn_o holds last value when not updated.
- Reset mid-walk: state IDLE, entries invalid; subsequent walker response ignored.

## Test plan
- Cold miss VPN 0x0000123, walker ready immediately, resp 2 cycles later PPN 0x0ABCD → miss=1 for 3 cycles, ptw_v pulse with ppn 0x0ABCD; re-request 0x0000123 → hit, ppn 0x0ABCD 1 cycle later, no walk.
- Fill 9 distinct VPNs with ITLB_ENTRIES=8 → 9th evicts entry 0; re-request first VPN misses, eighth VPN hits.
- Walk with ptw_resp_xcpt_i=1 → ptw_v=1, xcpt=1; re-request same VPN → walks again (not cached).
- Kill in PTW_WAIT, then resp PPN 0x00055 → no ptw_v pulse, miss=0 next cycle after kill; next request for that VPN hits 0x00055.
- flush_i during PTW_WAIT → response pulses ptw_v but no fill; previously hitting VPNs now miss.
- Kill and ptw_req_ready_i same cycle in PTW_REQ → no walk issued, IDLE, busy_o=0 next cycle.
